alu_request_arbiter: RTL and testbench
======================================

// Module: alu_request_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (req0: main pipeline, req1: address/aux unit).
//  Round-robin grant, 2-stage pipeline: S1 issue regs drive the ALU, S2 regs capture its result.
//  Responses come back with valid/ready backpressure. Throughput is one operation per cycle.
//  Sits between the requesting units and the ALU, which keeps its 4-bit ALUOperation encoding.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  OP_WIDTH    4   ALU operation code width; fixed by the ALU encoding
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  req0_valid     in   1   requester 0 has an operation
//  req0_ready     out  1   requester 0 op accepted this cycle when valid&ready
//  req0_op        in   4   ALU operation code
//  req0_a/req0_b  in   W   operands
//  req0_shamt     in   5   shift amount (SLL/SRL)
//  req1_*         ...      same set for requester 1
//  rsp0_valid     out  1   response for requester 0 present
//  rsp0_ready     in   1   requester 0 takes the response
//  rsp1_valid     out  1   response for requester 1 present
//  rsp1_ready     in   1   requester 1 takes the response
//  rsp_result     out  W   result, shared by both responses
//  rsp_zero       out  1   ALU zero flag of the result
//  rsp_err        out  1   op code was illegal
//  alu_operation  out  4   to ALU
//  alu_a/alu_b    out  W   to ALU
//  alu_shamt      out  5   to ALU
//  alu_result     in   W   from ALU (combinational)
//  alu_zero       in   1   from ALU
// BEHAVIOUR
//  Reset (sync): s1_valid=s2_valid=0, last_grant=1 (req0 wins first), S2 result/zero/err=0.
//   While reset=1, reqN_ready=0 and rspN_valid=0.
//   Reset mid-operation drops in-flight ops silently; no response is issued for them.
//  Idle ALU drive (s1_valid=0): alu_operation=4'b1001, alu_a=alu_b=0, alu_shamt=0.
//  stall2 = s2_valid & ~rspX_ready, where X = s2_owner.
//  adv1 = s1_valid & ~stall2.  can_accept = ~s1_valid | adv1.
//  Grant rules:
//   - Only one valid -> that requester wins.
//   - Both valid -> the requester != last_grant wins.
//   - last_grant updates only on an actual accept.
//  reqN_ready = can_accept & grant==N, combinational. Requesters hold valid and fields stable until accepted.
//  Accept at cycle T: op, a, b, shamt and owner load into S1. ALU inputs reflect them at T+1.
//  S1 -> S2 on adv1: S2 captures alu_result, alu_zero, owner.
//   rspN_valid = s2_valid & owner==N, first asserted at T+2.
//  Response drain and new S2 capture in the same cycle are allowed (no bubble).
//   S2 only clears on handshake with no advance.
//  Stall: S2 held, S1 held, readies low. Order is preserved; no op is lost or duplicated.
//  Legal ops: 4'b0000..4'b0111.
//  Illegal op: accepted normally, ALU driven with 4'b1001, S2 stores result=0, zero=0, err=1.
//  Zero flag passes through from alu_zero for legal ops.
//  Response outputs are registered and hold their value while valid&~ready.
// TESTING
//  1. req0 op=0011 a=5 b=7, rsp0_ready=1 -> accepted T; alu_operation=0011 at T+1; rsp0_valid T+2, result=12, zero=0.
//  2. Both valid 6 cycles, rsp ready=1 -> grants 0,1,0,1,0,1; 6 responses on consecutive cycles, correct owners.
//  3. rsp0_ready=0 for 3 cycles, 2 ops queued -> S2/S1 frozen, readies 0; results in order after release.
//  4. req1 op=1010 -> alu_operation=1001; rsp1_valid with err=1, result=0.
//  5. reset pulse with S1 and S2 full -> next cycle all valids 0, no responses; then both valid -> req0 granted.
//  6. req1 op=0100 a=9 b=9 -> result=0, zero=1, err=0.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Two-stage pipeline: S1 issue registers drive the ALU, S2 captures the result for the response.
module alu_request_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [4:0]            req0_shamt,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [4:0]            req1_shamt,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [OP_WIDTH-1:0]   alu_operation,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  localparam logic [OP_WIDTH-1:0] OP_IDLE     = OP_WIDTH'(4'b1001);
  localparam logic [OP_WIDTH-1:0] OP_LEGAL_LIM = OP_WIDTH'(4'b1000);

  logic                  s1_valid_q;
  logic                  s1_owner_q;
  logic [OP_WIDTH-1:0]   s1_op_q;
  logic [DATA_WIDTH-1:0] s1_a_q;
  logic [DATA_WIDTH-1:0] s1_b_q;
  logic [4:0]            s1_shamt_q;

  logic                  s2_valid_q;
  logic                  s2_owner_q;
  logic [DATA_WIDTH-1:0] s2_result_q;
  logic                  s2_zero_q;
  logic                  s2_err_q;

  logic last_grant_q;
  logic grant;
  logic owner_ready;
  logic stall2;
  logic adv1;
  logic can_accept;
  logic accept;
  logic s1_illegal;

  // Alternate only when both compete; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    owner_ready = s2_owner_q ? rsp1_ready : rsp0_ready;
    stall2      = s2_valid_q & ~owner_ready;
    adv1        = s1_valid_q & ~stall2;
    can_accept  = ~s1_valid_q | adv1;
    req0_ready  = ~reset & can_accept & ~grant;
    req1_ready  = ~reset & can_accept & grant;
    accept      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    s1_illegal  = (s1_op_q >= OP_LEGAL_LIM);
  end

  // Idle or illegal slots present a neutral operation to the ALU.
  always_comb begin
    alu_operation = OP_IDLE;
    alu_a         = '0;
    alu_b         = '0;
    alu_shamt     = '0;
    if (s1_valid_q && !s1_illegal) begin
      alu_operation = s1_op_q;
      alu_a         = s1_a_q;
      alu_b         = s1_b_q;
      alu_shamt     = s1_shamt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      last_grant_q <= 1'b1;
      s2_owner_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_err_q     <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q   <= 1'b1;
        last_grant_q <= grant;
      end else if (adv1) begin
        s1_valid_q <= 1'b0;
      end
      // A draining response and a new capture may share a cycle.
      if (adv1) begin
        s2_valid_q  <= 1'b1;
        s2_owner_q  <= s1_owner_q;
        s2_result_q <= s1_illegal ? '0 : alu_result;
        s2_zero_q   <= s1_illegal ? 1'b0 : alu_zero;
        s2_err_q    <= s1_illegal;
      end else if (s2_valid_q && owner_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_owner_q <= grant;
      s1_op_q    <= grant ? req1_op    : req0_op;
      s1_a_q     <= grant ? req1_a     : req0_a;
      s1_b_q     <= grant ? req1_b     : req0_b;
      s1_shamt_q <= grant ? req1_shamt : req0_shamt;
    end
  end

  always_comb begin
    rsp0_valid = ~reset & s2_valid_q & ~s2_owner_q;
    rsp1_valid = ~reset & s2_valid_q & s2_owner_q;
    rsp_result = s2_result_q;
    rsp_zero   = s2_zero_q;
    rsp_err    = s2_err_q;
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Scoreboard bench for alu_request_arbiter with a behavioural ALU model.
// Stimulus pushes expected responses; a monitor pops and compares on each response handshake.
module tb_alu_request_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [3:0]  alu_operation;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } req_t;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_request_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Op 1001 deliberately returns a nonzero result with zero set, so the arbiter must mask it.
  always_comb begin
    case (alu_operation)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a - alu_b;
      4'b0101: alu_result = alu_a << alu_shamt;
      4'b0110: alu_result = alu_a >> alu_shamt;
      4'b0111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hffff_ffff;
    endcase
    alu_zero = (alu_result == 32'h0) | alu_operation[3];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester drivers: present queue heads, retire them on a sampled handshake.
  initial begin
    bit acc0, acc1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
    forever begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (acc0) q0.delete(0);
      if (acc1) q1.delete(0);
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin
        req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; req0_shamt = q0[0].sh;
      end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; req1_shamt = q1[0].sh;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid && rsp1_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_both: rsp0_valid and rsp1_valid both 1, required one-hot at %0t", $time);
      end else if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_extra: response 0x%08h seen, none expected at %0t", rsp_result, $time);
        end else begin
          check("rsp_owner", 32'(rsp1_valid), 32'(sb[0].owner));
          check("rsp_result", rsp_result, sb[0].res);
          check("rsp_zero", 32'(rsp_zero), 32'(sb[0].zero));
          check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          sb.delete(0);
        end
      end
    end
  end

  task automatic push_req(input bit who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input bit want_rsp,
                          input logic [31:0] res, input logic zero, input logic err);
    req_t r;
    exp_t e;
    r.op = op; r.a = a; r.b = b; r.sh = sh;
    if (who) q1.push_back(r);
    else q0.push_back(r);
    if (want_rsp) begin
      e.owner = who; e.res = res; e.zero = zero; e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic drive_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input bit who, input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (!(who ? req1_valid : req0_valid) && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (i >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: request valid never seen within 20 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_req0_ready", 32'(req0_ready), 32'd0);
    check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    drive_step();
    reset = 1'b0;
    @(negedge clk);
    check("idle_alu_op", 32'(alu_operation), 32'h9);
    check("idle_alu_a", alu_a, 32'd0);
    check("idle_req0_ready", 32'(req0_ready), 32'd1);

    // Single add from req0 with latency checks.
    drive_step();
    push_req(1'b0, 4'b0011, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 1'b0, 1'b0);
    wait_valid(1'b0, "t1_wait");
    check("t1_accept", 32'(req0_ready), 32'd1);
    @(negedge clk);
    check("t1_alu_op", 32'(alu_operation), 32'h3);
    check("t1_alu_a", alu_a, 32'd5);
    @(negedge clk);
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    drain("t1_drain");

    // Equal operands through subtract give zero flag.
    drive_step();
    push_req(1'b1, 4'b0100, 32'd9, 32'd9, 5'd0, 1'b1, 32'd0, 1'b1, 1'b0);
    drain("t6_drain");

    // Both requesters compete; last grant was req1 so req0 leads.
    drive_step();
    push_req(1'b0, 4'b0000, 32'h0000_f0f0, 32'h0000_0ff0, 5'd0, 1'b1, 32'h0000_00f0, 1'b0, 1'b0);
    push_req(1'b1, 4'b0101, 32'd1, 32'd0, 5'd4, 1'b1, 32'd16, 1'b0, 1'b0);
    push_req(1'b0, 4'b0001, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3, 1'b0, 1'b0);
    push_req(1'b1, 4'b0110, 32'h80, 32'd0, 5'd3, 1'b1, 32'h10, 1'b0, 1'b0);
    push_req(1'b0, 4'b0010, 32'hffff_0000, 32'hffff_ffff, 5'd0, 1'b1, 32'h0000_ffff, 1'b0,
             1'b0);
    push_req(1'b1, 4'b0111, 32'd3, 32'd5, 5'd0, 1'b1, 32'd1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20 && !(rsp0_valid || rsp1_valid); i++) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (rsp0_valid || rsp1_valid) cnt++;
      @(negedge clk);
    end
    check("t2_back_to_back", 32'(cnt), 32'd6);
    drain("t2_drain");

    // Backpressure on rsp0 with two ops queued behind it.
    drive_step();
    rsp0_ready = 1'b0;
    push_req(1'b0, 4'b0011, 32'd100, 32'd23, 5'd0, 1'b1, 32'd123, 1'b0, 1'b0);
    push_req(1'b0, 4'b0100, 32'd50, 32'd8, 5'd0, 1'b1, 32'd42, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("t3_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t3_req0_ready", 32'(req0_ready), 32'd0);
    check("t3_alu_op_held", 32'(alu_operation), 32'h4);
    check("t3_result", rsp_result, 32'd123);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold", rsp_result, 32'd123);
    end
    drive_step();
    rsp0_ready = 1'b1;
    drain("t3_drain");

    // Illegal op from req1.
    drive_step();
    push_req(1'b1, 4'b1010, 32'd3, 32'd4, 5'd0, 1'b1, 32'd0, 1'b0, 1'b1);
    wait_valid(1'b1, "t4_wait");
    check("t4_accept", 32'(req1_ready), 32'd1);
    @(negedge clk);
    check("t4_alu_op", 32'(alu_operation), 32'h9);
    drain("t4_drain");

    // Reset with both stages full drops the in-flight ops.
    drive_step();
    rsp0_ready = 1'b0;
    push_req(1'b0, 4'b0011, 32'd1, 32'd1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    push_req(1'b0, 4'b0011, 32'd2, 32'd2, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("t5_s2_full", 32'(rsp0_valid), 32'd1);
    check("t5_s1_full", 32'(req0_ready), 32'd0);
    drive_step();
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_rsp0", 32'(rsp0_valid), 32'd0);
    check("t5_rst_ready0", 32'(req0_ready), 32'd0);
    drive_step();
    reset = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("t5_post_rsp0", 32'(rsp0_valid), 32'd0);
    check("t5_post_rsp1", 32'(rsp1_valid), 32'd0);
    drive_step();
    push_req(1'b0, 4'b0011, 32'd10, 32'd20, 5'd0, 1'b1, 32'd30, 1'b0, 1'b0);
    push_req(1'b1, 4'b0010, 32'hff, 32'h0f, 5'd0, 1'b1, 32'hf0, 1'b0, 1'b0);
    wait_valid(1'b0, "t5_wait");
    check("t5_both_valid", 32'(req1_valid), 32'd1);
    check("t5_grant0", 32'(req0_ready), 32'd1);
    check("t5_grant1", 32'(req1_ready), 32'd0);
    drain("t5_drain");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
